// File: rtl/load_store_unit_if.sv
// Interface bundling the core request/response handshake and the word-only
// data_memory port of the load/store unit.
//   slave  : the load_store_unit side (takes requests, drives memory)
//   master : the core + memory side (issues requests, returns mem_RD)
// Signals:
//   req_valid/req_ready/req_we/req_size/req_signed/req_addr/req_wdata : request
//   rsp_valid/rsp_rdata/rsp_err                                       : response
//   stall                                                             : core freeze
//   mem_A/mem_WE/mem_WD/mem_RD                                        : data_memory
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              stall;
  logic [ADDR_W-1:0] mem_A;
  logic              mem_WE;
  logic [31:0]       mem_WD;
  logic [31:0]       mem_RD;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_RD,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall, mem_A, mem_WE, mem_WD
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_RD,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall, mem_A, mem_WE, mem_WD
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: converts byte/half/word loads and stores from the core into
// word-only data_memory accesses. Sub-word stores are done as read-modify-write.
// Loads return the addressed lane, sign- or zero-extended.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   reset : asynchronous, active-high
//   bus   : load_store_unit_if.slave (request, response, stall, memory port)
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t            state;
  state_t            state_nxt;

  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem_wd_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic              accept;
  logic              misaligned;
  logic              req_bad;

  // Extract the addressed lane of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] rd,
                                              input logic [1:0]  size,
                                              input logic        sgn,
                                              input logic [1:0]  lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = rd[8*lane +: 8];
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (size)
      SZ_BYTE: r = sgn ? 32'(b) : {24'd0, b};
      SZ_HALF: r = sgn ? 32'(h) : {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of a memory word with right-justified store data.
  function automatic logic [31:0] store_merge(input logic [31:0] rd,
                                              input logic [31:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = rd;
    case (size)
      SZ_BYTE: r[8*lane +: 8] = wd[7:0];
      SZ_HALF: begin
        if (lane[1]) r[31:16] = wd[15:0];
        else         r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  assign accept     = bus.req_valid && (state == S_IDLE);
  assign misaligned = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                      ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
  assign req_bad    = misaligned || (bus.req_size == 2'b11);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_bad)                       state_nxt = S_RESP;
          else if (!bus.req_we)              state_nxt = S_LOAD;
          else if (bus.req_size == SZ_WORD)  state_nxt = S_WRITE;
          else                               state_nxt = S_READ;
        end
      end
      S_LOAD:  state_nxt = S_RESP;
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch, write-data build and response capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_q      <= '0;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_wd_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            if (req_bad) begin
              // Errors respond straight away; nothing touches memory.
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
              mem_wd_q <= bus.req_wdata;
            end
          end
        end
        S_LOAD: begin
          rsp_rdata_q <= load_extend(bus.mem_RD, size_q, signed_q, addr_q[1:0]);
          rsp_err_q   <= 1'b0;
        end
        S_READ: begin
          mem_wd_q <= store_merge(bus.mem_RD, wdata_q, size_q, addr_q[1:0]);
        end
        S_WRITE: begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Strobes are decoded from state so reset removes them immediately.
  assign bus.req_ready = (state == S_IDLE);
  assign bus.stall     = (state != S_IDLE);
  assign bus.mem_WE    = (state == S_WRITE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.mem_A     = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_WD    = mem_wd_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;

  logic clk;
  logic reset;
  int   ntests;
  int   nfail;
  int   nwr;
  logic [31:0] last_wa;
  logic [31:0] mem [64];

  load_store_unit_if #(.ADDR_W(32)) mif ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on rising edge when mem_WE.
  assign mif.mem_RD = mem[mif.mem_A[7:2]];
  always @(posedge clk) begin
    if (mif.mem_WE) begin
      mem[mif.mem_A[7:2]] <= mif.mem_WD;
      nwr     <= nwr + 1;
      last_wa <= mif.mem_A;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request in IDLE, return cycles from accept edge to rsp_valid.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat);
    @(negedge clk);
    mif.req_valid  = 1'b1;
    mif.req_we     = we;
    mif.req_size   = size;
    mif.req_signed = sgn;
    mif.req_addr   = addr;
    mif.req_wdata  = wdata;
    @(posedge clk);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      mif.req_valid = 1'b0;
      lat++;
      if (mif.rsp_valid) break;
    end
  endtask

  logic [31:0] t6_addr [3];
  logic [1:0]  t6_size [3];
  logic [31:0] t6_exp  [3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int w0;
    ntests = 0;
    nfail  = 0;
    mif.req_valid  = 1'b0;
    mif.req_we     = 1'b0;
    mif.req_size   = 2'b00;
    mif.req_signed = 1'b0;
    mif.req_addr   = '0;
    mif.req_wdata  = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready",     mif.req_ready, 1);
    check("rst_stall",     mif.stall,     0);
    check("rst_rsp_valid", mif.rsp_valid, 0);
    check("rst_rdata",     mif.rsp_rdata, 0);
    check("rst_err",       mif.rsp_err,   0);
    check("rst_mem_we",    mif.mem_WE,    0);
    check("rst_mem_a",     mif.mem_A,     0);
    check("rst_mem_wd",    mif.mem_WD,    0);

    // 1: word store then word load
    w0 = nwr;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat);
    check("sw_lat",    lat, 2);
    check("sw_writes", nwr - w0, 1);
    check("sw_addr",   last_wa, 32'h10);
    check("sw_mem",    mem[4], 32'hDEADBEEF);
    check("sw_rdata",  mif.rsp_rdata, 0);
    check("sw_err",    mif.rsp_err, 0);
    w0 = nwr;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat);
    check("lw_lat",    lat, 2);
    check("lw_rdata",  mif.rsp_rdata, 32'hDEADBEEF);
    check("lw_err",    mif.rsp_err, 0);
    check("lw_writes", nwr - w0, 0);

    // 2: byte store read-modify-write
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat);
    w0 = nwr;
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, lat);
    check("sb_lat",    lat, 3);
    check("sb_writes", nwr - w0, 1);
    check("sb_mem",    mem[4], 32'h1122A544);
    check("sb_rdata",  mif.rsp_rdata, 0);

    // 3: sub-word loads with sign/zero extension, then a half store
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, lat);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat);
    check("lb_13",  mif.rsp_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat);
    check("lbu_13", mif.rsp_rdata, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat);
    check("lh_12",  mif.rsp_rdata, 32'hFFFF80FF);
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat);
    check("lhu_10", mif.rsp_rdata, 32'h00007F01);
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat);
    check("lb_11",  mif.rsp_rdata, 32'h0000007F);
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, lat);
    check("sh_lat", lat, 3);
    check("sh_mem", mem[4], 32'h12347F01);

    // 4: misaligned accesses
    w0 = nwr;
    do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, lat);
    check("lw12_err",   mif.rsp_err, 1);
    check("lw12_rdata", mif.rsp_rdata, 0);
    check("lw12_lat",   lat, 1);
    do_req(1'b0, 2'b01, 1'b1, 32'h11, 32'h0, lat);
    check("lh11_err",   mif.rsp_err, 1);
    check("lh11_rdata", mif.rsp_rdata, 0);
    check("lh11_lat",   lat, 1);
    do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h55555555, lat);
    check("rsv_err",    mif.rsp_err, 1);
    check("err_writes", nwr - w0, 0);
    check("err_mem",    mem[4], 32'h12347F01);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat);
    check("err_clear",  mif.rsp_err, 0);

    // 5: reset during READ of a byte store
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat);
    w0 = nwr;
    @(negedge clk);
    mif.req_valid = 1'b1;
    mif.req_we    = 1'b1;
    mif.req_size  = 2'b00;
    mif.req_addr  = 32'h10;
    mif.req_wdata = 32'h000000EE;
    @(posedge clk);
    @(negedge clk);
    mif.req_valid = 1'b0;
    check("rmw_stall", mif.stall, 1);
    #1 reset = 1'b1;
    #1;
    check("rmw_rst_we",    mif.mem_WE, 0);
    check("rmw_rst_ready", mif.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rmw_writes", nwr - w0, 0);
    check("rmw_mem",    mem[4], 32'h11223344);
    check("rmw_valid",  mif.rsp_valid, 0);
    check("rmw_rdata",  mif.rsp_rdata, 0);
    check("rmw_err",    mif.rsp_err, 0);
    check("rmw_wd",     mif.mem_WD, 0);
    check("rmw_a",      mif.mem_A, 0);

    // 6: req_valid held high across three loads
    do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEF00D, lat);
    t6_addr[0] = 32'h10; t6_size[0] = 2'b10; t6_exp[0] = 32'h11223344;
    t6_addr[1] = 32'h14; t6_size[1] = 2'b10; t6_exp[1] = 32'hCAFEF00D;
    t6_addr[2] = 32'h11; t6_size[2] = 2'b00; t6_exp[2] = 32'h00000033;
    @(negedge clk);
    mif.req_valid  = 1'b1;
    mif.req_we     = 1'b0;
    mif.req_signed = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("hold_ready_%0d", i), mif.req_ready, (i % 3 == 0) ? 1 : 0);
      check($sformatf("hold_stall_%0d", i), mif.stall,     (i % 3 != 0) ? 1 : 0);
      check($sformatf("hold_valid_%0d", i), mif.rsp_valid, (i % 3 == 2) ? 1 : 0);
      if (i % 3 == 2)
        check($sformatf("hold_rdata_%0d", i / 3), mif.rsp_rdata, t6_exp[i / 3]);
      if (i % 3 == 0) begin
        mif.req_addr = t6_addr[i / 3];
        mif.req_size = t6_size[i / 3];
      end
      @(negedge clk);
    end
    mif.req_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
